// File: rtl/ms_bank_sequencer_pkg.sv
// Shared definitions for the master-slave SR bank sequencer.
package ms_bank_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MASTER,
        S_CLOSE,
        S_SLAVE,
        S_ACK
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    localparam int unsigned HOLD_CYC_DEFAULT = 2;
    localparam int unsigned HOLD_CNT_W       = 4;

endpackage

// File: rtl/ms_bank_sequencer_if.sv
// Requester-side bus of the bank sequencer: requests in, grant/ack/read-back out.
interface ms_bank_sequencer_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_op;
    logic [NUM_REQ*WIDTH-1:0] req_mask;
    logic [NUM_REQ-1:0]       gnt;
    logic                     ack;
    logic [WIDTH-1:0]         rd_data;

    modport master (
        output req, req_op, req_mask,
        input  gnt, ack, rd_data
    );

    modport slave (
        input  req, req_op, req_mask,
        output gnt, ack, rd_data
    );
endinterface

// File: rtl/ms_bank_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after rr_ptr_i.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    // Circular priority search starting at the round-robin pointer.
    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ms_bank_sequencer.sv
// Round-robin sequencer driving a shared master-slave SR flip-flop bank in a glitch-safe phase order.
module ms_bank_sequencer
    import ms_bank_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ms_bank_sequencer_if.slave   req_if,
    output logic [WIDTH-1:0]     bank_s,
    output logic [WIDTH-1:0]     bank_r,
    output logic                 bank_c,
    input  logic [WIDTH-1:0]     bank_q
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                  state_q;
    logic [PW-1:0]           rr_ptr_q;
    logic [PW-1:0]           idx_q;
    logic                    op_q;
    logic [WIDTH-1:0]        mask_q;
    logic [HOLD_CNT_W-1:0]   hold_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic                    ack_q;
    logic [WIDTH-1:0]        rd_data_q;
    logic [WIDTH-1:0]        bank_s_q;
    logic [WIDTH-1:0]        bank_r_q;
    logic                    bank_c_q;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [PW-1:0]           arb_idx;
    logic                    arb_op;
    logic [WIDTH-1:0]        arb_mask;
    logic [PW-1:0]           rr_ptr_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req_i    (req_if.req),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (arb_gnt)
    );

    // Encode the one-hot grant and pick out the winner's op and mask.
    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = PW'(i);
            end
        end
        arb_op   = req_if.req_op[arb_idx];
        arb_mask = req_if.req_mask[arb_idx*WIDTH +: WIDTH];
        rr_ptr_d = (idx_q == PW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    end

    // Sequencer FSM with registered bank and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            op_q      <= OP_CLR;
            mask_q    <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
            bank_s_q  <= '0;
            bank_r_q  <= '0;
            bank_c_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req_if.req) begin
                        gnt_q    <= arb_gnt;
                        idx_q    <= arb_idx;
                        op_q     <= arb_op;
                        mask_q   <= arb_mask;
                        bank_s_q <= (arb_op == OP_SET) ? arb_mask : '0;
                        bank_r_q <= (arb_op == OP_CLR) ? arb_mask : '0;
                        bank_c_q <= 1'b0;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    bank_s_q <= (op_q == OP_SET) ? mask_q : '0;
                    bank_r_q <= (op_q == OP_CLR) ? mask_q : '0;
                    bank_c_q <= 1'b1;
                    hold_q   <= HOLD_CNT_W'(HOLD_CYC - 1);
                    state_q  <= S_MASTER;
                end
                S_MASTER: begin
                    if (hold_q == '0) begin
                        bank_s_q <= '0;
                        bank_r_q <= '0;
                        state_q  <= S_CLOSE;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                S_CLOSE: begin
                    bank_c_q <= 1'b0;
                    state_q  <= S_SLAVE;
                end
                S_SLAVE: begin
                    // Slave has settled with C low; capture so rd_data is valid alongside ack.
                    ack_q     <= 1'b1;
                    rd_data_q <= bank_q;
                    state_q   <= S_ACK;
                end
                S_ACK: begin
                    gnt_q    <= '0;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_if.gnt     = gnt_q;
    assign req_if.ack     = ack_q;
    assign req_if.rd_data = rd_data_q;
    assign bank_s         = bank_s_q;
    assign bank_r         = bank_r_q;
    assign bank_c         = bank_c_q;

endmodule

// File: tb/tb_ms_bank_sequencer.sv
// Self-checking bench for ms_bank_sequencer with a behavioural SR bank and a reference model.
module tb_ms_bank_sequencer;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 2;

    localparam int MODE_NONE  = 0;
    localparam int MODE_LATCH = 1;
    localparam int MODE_DROP  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] bank_s, bank_r, bank_q;
    logic         bank_c;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           ref_ptr = 0;
    logic [W-1:0] ref_bank = '0;

    always #5 clk = ~clk;

    ms_bank_sequencer_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    ms_bank_sequencer #(
        .NUM_REQ  (N),
        .WIDTH    (W),
        .HOLD_CYC (H)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_if (bus),
        .bank_s (bank_s),
        .bank_r (bank_r),
        .bank_c (bank_c),
        .bank_q (bank_q)
    );

    // Behavioural master-slave SR bank: master transparent while C=1, slave follows while C=0.
    logic [W-1:0] m_v = '0;
    logic [W-1:0] s_v = '0;
    always @(bank_c or bank_s or bank_r) if (bank_c) m_v = (m_v | bank_s) & ~bank_r;
    always @(bank_c or m_v) if (!bank_c) s_v = m_v;
    assign bank_q = s_v;

    // S and R must never both be asserted on any bit.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_cmp++;
            if ((bank_s & bank_r) !== '0) begin
                n_bad++;
                $display("FAIL sr_overlap: s=%h r=%h, required s&r=0", bank_s, bank_r);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Runs one transaction starting at a negedge of an IDLE cycle with req already driven.
    task automatic do_txn(input int mode, output int w_o);
        int           w, ack_k, c_cnt;
        bit           gnt_bad, c_bad, sr_bad;
        logic         op, exp_c;
        logic [W-1:0] m, exp_rd, exp_s, exp_r;
        logic [N-1:0] exp_g;
        w = -1; ack_k = -1; c_cnt = 0;
        gnt_bad = 0; c_bad = 0; sr_bad = 0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (ref_ptr + i) % N;
            if (w < 0 && bus.req[j]) w = j;
        end
        w_o = w;
        if (w < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_setup: req=%b, required a pending request", bus.req);
            return;
        end
        op     = bus.req_op[w];
        m      = bus.req_mask[w*W +: W];
        exp_g  = '0;
        exp_g[w] = 1'b1;
        exp_rd = op ? (ref_bank | m) : (ref_bank & ~m);

        n_cmp++;
        if (bus.gnt !== '0 || bus.ack !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_entry: gnt=%b ack=%b, required 0/0", bus.gnt, bus.ack);
        end

        for (int k = 1; k <= 30 && ack_k < 0; k++) begin
            @(negedge clk);
            if (bus.gnt !== exp_g) gnt_bad = 1;
            if (bus.ack === 1'b1) ack_k = k;
            exp_c = (k >= 2 && k <= H + 2) ? 1'b1 : 1'b0;
            if (bank_c !== exp_c) c_bad = 1;
            if (bank_c === 1'b1) c_cnt++;
            exp_s = (k <= H + 1 && op)  ? m : '0;
            exp_r = (k <= H + 1 && !op) ? m : '0;
            if (bank_s !== exp_s || bank_r !== exp_r) sr_bad = 1;
            if (k == 2 && mode == MODE_LATCH) bus.req_mask[w*W +: W] = ~m;
            if (k == 2 && mode == MODE_DROP)  bus.req[w] = 1'b0;
        end

        n_cmp++;
        if (ack_k != H + 4) begin
            n_bad++;
            $display("FAIL ack_latency: ack at cycle %0d, required %0d", ack_k, H + 4);
        end
        n_cmp++;
        if (gnt_bad) begin
            n_bad++;
            $display("FAIL grant: last gnt=%b, required %b throughout", bus.gnt, exp_g);
        end
        n_cmp++;
        if (c_bad || c_cnt != H + 1) begin
            n_bad++;
            $display("FAIL c_phase: C high %0d cycles (window error=%0d), required %0d", c_cnt, c_bad, H + 1);
        end
        n_cmp++;
        if (sr_bad) begin
            n_bad++;
            $display("FAIL sr_window: s=%h r=%h at end, required op=%0d mask=%h in SETUP/MASTER only", bank_s, bank_r, op, m);
        end
        n_cmp++;
        if (bus.rd_data !== exp_rd) begin
            n_bad++;
            $display("FAIL rd_data: got %h, required %h", bus.rd_data, exp_rd);
        end

        @(negedge clk);
        n_cmp++;
        if (bus.ack !== 1'b0 || bus.gnt !== '0 || bus.rd_data !== exp_rd) begin
            n_bad++;
            $display("FAIL ack_release: ack=%b gnt=%b rd=%h, required 0/0/%h", bus.ack, bus.gnt, bus.rd_data, exp_rd);
        end
        ref_bank = exp_rd;
        ref_ptr  = (w + 1) % N;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_op = '0; bus.req_mask = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.gnt !== '0 || bus.ack !== 1'b0 || bus.rd_data !== '0 ||
            bank_s !== '0 || bank_r !== '0 || bank_c !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: gnt=%b ack=%b rd=%h s=%h r=%h c=%b, required all 0",
                     bus.gnt, bus.ack, bus.rd_data, bank_s, bank_r, bank_c);
        end
        rst_n = 1'b1;
        ref_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single_set();
        int w;
        bus.req_op[0] = 1'b1;
        bus.req_mask[0*W +: W] = 8'h05;
        bus.req[0] = 1'b1;
        do_txn(MODE_NONE, w);
        bus.req[0] = 1'b0;
        n_cmp++;
        if (bus.rd_data !== 8'h05) begin
            n_bad++;
            $display("FAIL single_set: rd=%h, required 05", bus.rd_data);
        end
    endtask

    task automatic test_clear_after_set();
        int w;
        bus.req_op[1] = 1'b1;
        bus.req_mask[1*W +: W] = 8'h0F;
        bus.req[1] = 1'b1;
        do_txn(MODE_NONE, w);
        bus.req[1] = 1'b0;
        bus.req_op[2] = 1'b0;
        bus.req_mask[2*W +: W] = 8'h03;
        bus.req[2] = 1'b1;
        do_txn(MODE_NONE, w);
        bus.req[2] = 1'b0;
        n_cmp++;
        if (bus.rd_data !== 8'h0C) begin
            n_bad++;
            $display("FAIL clear_after_set: rd=%h, required 0C", bus.rd_data);
        end
    endtask

    task automatic test_round_robin();
        int w;
        for (int i = 0; i < N; i++) begin
            bus.req_op[i] = 1'($urandom);
            bus.req_mask[i*W +: W] = W'($urandom);
        end
        bus.req = '1;
        for (int t = 0; t < N + 1; t++) begin
            do_txn(MODE_NONE, w);
        end
        bus.req = '0;
    endtask

    task automatic test_latch_at_grant();
        int           w;
        logic [W-1:0] prior;
        prior = ref_bank;
        bus.req_op[1] = 1'b1;
        bus.req_mask[1*W +: W] = 8'hF0;
        bus.req[1] = 1'b1;
        do_txn(MODE_LATCH, w);
        bus.req[1] = 1'b0;
        n_cmp++;
        if (bus.rd_data !== (prior | 8'hF0)) begin
            n_bad++;
            $display("FAIL latch_at_grant: rd=%h, required %h", bus.rd_data, prior | 8'hF0);
        end
    endtask

    task automatic test_reset_abort();
        int           r, w;
        bit           ack_seen;
        logic [W-1:0] m;
        r = ref_ptr;
        m = ref_bank & W'($urandom);
        bus.req_op[r] = 1'b1;
        bus.req_mask[r*W +: W] = m;
        bus.req = '0;
        bus.req[r] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bank_c !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_reach_master: c=%b, required 1", bank_c);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.gnt !== '0 || bank_c !== 1'b0 || bank_s !== '0 || bank_r !== '0 || bus.ack !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_outputs: gnt=%b c=%b s=%h r=%h ack=%b, required all 0",
                     bus.gnt, bank_c, bank_s, bank_r, bus.ack);
        end
        bus.req = '0;
        ack_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ack !== 1'b0) ack_seen = 1;
        end
        n_cmp++;
        if (ack_seen || bank_q !== ref_bank) begin
            n_bad++;
            $display("FAIL abort_no_ack: ack_seen=%0d bank=%h, required 0/%h", ack_seen, bank_q, ref_bank);
        end
        rst_n = 1'b1;
        ref_ptr = 0;
        bus.req_op[0] = 1'($urandom);
        bus.req_mask[0*W +: W] = W'($urandom);
        bus.req_op[3] = 1'($urandom);
        bus.req_mask[3*W +: W] = W'($urandom);
        bus.req = 4'b1001;
        do_txn(MODE_NONE, w);
        bus.req = '0;
    endtask

    task automatic test_empty_mask_and_drop();
        int           w, acks;
        logic [W-1:0] prior;
        prior = ref_bank;
        bus.req_op[2] = 1'($urandom);
        bus.req_mask[2*W +: W] = '0;
        bus.req[2] = 1'b1;
        do_txn(MODE_NONE, w);
        bus.req[2] = 1'b0;
        n_cmp++;
        if (bus.rd_data !== prior || bank_q !== prior) begin
            n_bad++;
            $display("FAIL empty_mask: rd=%h bank=%h, required %h", bus.rd_data, bank_q, prior);
        end
        bus.req_op[3] = 1'($urandom);
        bus.req_mask[3*W +: W] = W'($urandom);
        bus.req[3] = 1'b1;
        do_txn(MODE_DROP, w);
        acks = 0;
        repeat (H + 6) begin
            @(negedge clk);
            if (bus.ack === 1'b1) acks++;
        end
        n_cmp++;
        if (acks != 0 || bus.gnt !== '0) begin
            n_bad++;
            $display("FAIL drop_single_ack: extra acks=%0d gnt=%b, required 0/0", acks, bus.gnt);
        end
    endtask

    task automatic test_random();
        int w, mode;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && ($urandom_range(1, 0) == 1)) begin
                    bus.req_op[i] = 1'($urandom);
                    bus.req_mask[i*W +: W] = W'($urandom);
                    bus.req[i] = 1'b1;
                end
            end
            if (bus.req == '0) bus.req[$urandom_range(N - 1, 0)] = 1'b1;
            mode = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : MODE_NONE;
            do_txn(mode, w);
            if (w >= 0 && $urandom_range(3, 0) != 0) bus.req[w] = 1'b0;
        end
        bus.req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_clear_after_set();
        test_round_robin();
        test_latch_at_grant();
        test_reset_abort();
        test_empty_mask_and_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
